// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache placed in front of main memory.
// One word per line; read misses use the memory's enable/fetch_complete handshake.
module direct_mapped_cache #(
  parameter int unsigned ADDR_LENGTH = 10,
  parameter int unsigned BLOCK_SIZE  = 32,
  parameter int unsigned NUM_LINES   = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_LENGTH-1:0] cpu_addr,
  input  logic [BLOCK_SIZE-1:0]  cpu_data_in,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  output logic [BLOCK_SIZE-1:0]  cpu_data_out,
  output logic                   cpu_ready,
  output logic                   busy,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]  mem_data_out,
  output logic                   mem_write,
  output logic                   mem_enable,
  input  logic [BLOCK_SIZE-1:0]  mem_data_in,
  input  logic                   mem_fetch_complete,
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count
);

  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = ADDR_LENGTH - IdxW;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StWrite} state_e;

  state_e                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TagW-1:0]        tag_q  [NUM_LINES];
  logic [BLOCK_SIZE-1:0]  data_q [NUM_LINES];
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [BLOCK_SIZE-1:0]  wdata_q;

  logic [IdxW-1:0] req_idx, lat_idx;
  logic [TagW-1:0] req_tag, lat_tag;
  logic            req_hit, lat_hit, fill_en, wupd_en;

  always_comb begin
    req_idx = cpu_addr[IdxW-1:0];
    req_tag = cpu_addr[ADDR_LENGTH-1:IdxW];
    lat_idx = addr_q[IdxW-1:0];
    lat_tag = addr_q[ADDR_LENGTH-1:IdxW];
    req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    fill_en = !reset && (state_q == StFetch) && mem_fetch_complete;
    wupd_en = !reset && (state_q == StWrite) && lat_hit;
  end

  // A complete still high from an earlier fetch must hold off new requests.
  assign busy = (state_q != StIdle) || mem_fetch_complete;

  // Line storage needs no reset: valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[lat_idx] <= mem_data_in;
      tag_q[lat_idx]  <= lat_tag;
    end else if (wupd_en) begin
      data_q[lat_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_data_out <= '0;
      cpu_ready    <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_write    <= 1'b0;
      mem_enable   <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      mem_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!mem_fetch_complete) begin
            if (cpu_write) begin
              addr_q       <= cpu_addr;
              wdata_q      <= cpu_data_in;
              mem_addr     <= cpu_addr;
              mem_data_out <= cpu_data_in;
              mem_write    <= 1'b1;
              state_q      <= StWrite;
            end else if (cpu_read) begin
              addr_q <= cpu_addr;
              if (req_hit) begin
                cpu_data_out <= data_q[req_idx];
                cpu_ready    <= 1'b1;
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
              end else begin
                mem_addr   <= cpu_addr;
                mem_enable <= 1'b1;
                state_q    <= StFetch;
              end
            end
          end
        end
        StFetch: begin
          if (mem_fetch_complete) begin
            valid_q[lat_idx] <= 1'b1;
            cpu_data_out     <= mem_data_in;
            cpu_ready        <= 1'b1;
            mem_enable       <= 1'b0;
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            state_q          <= StDrain;
          end
        end
        StDrain: begin
          if (!mem_fetch_complete) state_q <= StIdle;
        end
        StWrite: begin
          cpu_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench: directed scenarios then random reads/writes against a line-map model.
module tb_direct_mapped_cache;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 16;
  localparam int unsigned CW = 3;  // narrow counters so saturation is reached
  localparam int          MEM_DELAY = 3;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data_in = '0;
  logic          cpu_read = 1'b0;
  logic          cpu_write = 1'b0;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic          mem_write, mem_enable;
  logic [DW-1:0] mem_data_in = '0;
  logic          mem_fetch_complete = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  direct_mapped_cache #(
    .ADDR_LENGTH(AW), .BLOCK_SIZE(DW), .NUM_LINES(NL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_data_out(cpu_data_out),
    .cpu_ready(cpu_ready), .busy(busy), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_write(mem_write), .mem_enable(mem_enable), .mem_data_in(mem_data_in),
    .mem_fetch_complete(mem_fetch_complete), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Main memory: complete rises MEM_DELAY edges after enable and holds until enable drops.
  logic [DW-1:0] tb_mem [1 << AW];
  int            mem_dly = 0;
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr] <= mem_data_out;
    if (mem_enable) begin
      if (mem_dly == MEM_DELAY - 1) begin
        mem_fetch_complete <= 1'b1;
        mem_data_in        <= tb_mem[mem_addr];
      end else begin
        mem_dly <= mem_dly + 1;
      end
    end else begin
      mem_dly            <= 0;
      mem_fetch_complete <= 1'b0;
    end
  end

  // Reference model: memory image plus which address each line holds (-1 = empty).
  logic [DW-1:0] ref_mem [1 << AW];
  int            line_addr [NL];
  int            exp_hits, exp_misses;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) line_addr[i] = -1;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One request, held until cpu_ready; records what the memory side saw along the way.
  task automatic op(input bit wr, input int a, input logic [DW-1:0] d, input bit both);
    int            lat = 0;
    bit            saw_en = 0, overlap = 0;
    int            pulses = 0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    int            idx;
    bit            hit;
    wait_idle();
    cpu_addr    = AW'(a);
    cpu_data_in = d;
    cpu_write   = wr;
    cpu_read    = !wr || both;
    do begin
      @(negedge clk);
      lat++;
      if (mem_enable) saw_en = 1;
      if (mem_write && mem_enable) overlap = 1;
      if (mem_write) begin
        pulses++;
        wa = mem_addr;
        wd = mem_data_out;
      end
    end while (!cpu_ready && lat < 50);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check("ready_timeout", {31'd0, cpu_ready}, 32'd1);
    check("wr_en_overlap", {31'd0, overlap}, 32'd0);
    idx = a % NL;
    if (wr) begin
      ref_mem[a] = d;
      check("wr_pulses", pulses, 1);
      check("wr_addr", {22'd0, wa}, a);
      check("wr_data", wd, d);
      check("wr_latency", lat, 2);
      check("wr_no_fetch", {31'd0, saw_en}, 32'd0);
    end else begin
      hit = (line_addr[idx] == a);
      check("rd_data", cpu_data_out, ref_mem[a]);
      check("rd_no_write", pulses, 0);
      check("rd_enable_low_at_ready", {31'd0, mem_enable}, 32'd0);
      if (hit) begin
        if (exp_hits < CNT_MAX) exp_hits++;
        check("hit_latency", lat, 1);
        check("hit_no_enable", {31'd0, saw_en}, 32'd0);
      end else begin
        if (exp_misses < CNT_MAX) exp_misses++;
        line_addr[idx] = a;
        check("miss_enable", {31'd0, saw_en}, 32'd1);
      end
    end
    check("hit_count", {29'd0, hit_count}, exp_hits);
    check("miss_count", {29'd0, miss_count}, exp_misses);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data_out"}, cpu_data_out, '0);
    check({tag, "_ready"}, {31'd0, cpu_ready}, 32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_data_out"}, mem_data_out, '0);
    check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, "_mem_enable"}, {31'd0, mem_enable}, 32'd0);
    check({tag, "_hit_count"}, {29'd0, hit_count}, 32'd0);
    check({tag, "_miss_count"}, {29'd0, miss_count}, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      tb_mem[i]  = DW'(i);
      ref_mem[i] = DW'(i);
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("reset");
    check("reset_busy", {31'd0, busy}, 32'd0);

    op(0, 10, '0, 0);             // cold miss
    op(0, 10, '0, 0);             // hit
    op(0, 26, '0, 0);             // alias evicts 10
    op(0, 10, '0, 0);             // miss again
    op(1, 50, 32'h0000ABCD, 0);   // write miss, no allocate
    op(0, 50, '0, 0);             // miss returning written data
    op(1, 10, 32'h55, 1);         // write hit with read also high
    op(0, 10, '0, 0);             // hit with updated data

    // Reset while the fetch of 7 is completing.
    wait_idle();
    cpu_addr = AW'(7);
    cpu_read = 1'b1;
    n = 0;
    while (!mem_fetch_complete && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fetch7_complete_seen", {31'd0, mem_fetch_complete}, 32'd1);
    cpu_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_zero_outputs("midfetch_reset");
    check("busy_while_complete", {31'd0, busy}, 32'd1);
    op(0, 7, '0, 0);

    for (int k = 0; k < 80; k++) begin
      int  a;
      bit  w;
      a = $urandom_range(0, 63);
      w = ($urandom_range(0, 2) == 0);
      op(w, a, $urandom, w && $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
